alarm_scheduler: RTL and testbench

ALARM_SCHEDULER -- requirements
Module: alarm_scheduler

---
 rtl/alarm_scheduler.sv | 139 +++++++++++++
 tb/tb_alarm_scheduler.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alarm_scheduler.sv
// Alarm clock scheduler: arms, rings on a time match, supports bounded snoozes and auto-silence.
// Matches are edge-qualified so a time held across several 2 Hz ticks triggers only once.
module alarm_scheduler #(
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic       CLK_2Hz,
  input  logic       reset,
  input  logic       run_clock,
  input  logic       activatealarm,
  input  logic       alarmreset,
  input  logic       snooze,
  input  logic [7:0] sec,
  input  logic [7:0] min,
  input  logic [7:0] hrs,
  input  logic [7:0] min_alrm,
  input  logic [7:0] hrs_alrm,
  output logic       alrm,
  output logic       snoozing,
  output logic [1:0] state,
  output logic [2:0] snooze_cnt
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StArmed   = 2'd1,
    StRinging = 2'd2,
    StSnooze  = 2'd3
  } state_e;

  localparam logic [7:0] RingLast  = 8'(2 * RING_SEC - 1);
  localparam logic [7:0] SnzMinAdd = 8'(SNOOZE_MIN);
  localparam logic [2:0] SnzMax    = 3'(MAX_SNOOZE);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] tmr_q, tmr_d;
  logic [7:0] snz_min_q, snz_min_d;
  logic [7:0] snz_hrs_q, snz_hrs_d;
  logic       alarm_match_q, snz_match_q, snooze_q;
  logic       alrm_q, snoozing_q;

  logic       alarm_match, snz_match;
  logic       alarm_rise, snz_rise, snooze_rise;
  logic [7:0] snz_sum;

  assign alarm_match = run_clock && (hrs == hrs_alrm) && (min == min_alrm) && (sec == 8'd0);
  assign snz_match   = run_clock && (hrs == snz_hrs_q) && (min == snz_min_q) && (sec == 8'd0);
  assign alarm_rise  = alarm_match && !alarm_match_q;
  assign snz_rise    = snz_match && !snz_match_q;
  assign snooze_rise = snooze && !snooze_q;
  assign snz_sum     = min + SnzMinAdd;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tmr_d     = tmr_q;
    snz_min_d = snz_min_q;
    snz_hrs_d = snz_hrs_q;
    if (!activatealarm) begin
      state_d = StIdle;
      cnt_d   = 3'd0;
    end else begin
      unique case (state_q)
        StIdle: state_d = StArmed;
        StArmed: begin
          if (alarm_rise) begin
            state_d = StRinging;
            tmr_d   = 8'd0;
          end
        end
        StRinging: begin
          tmr_d = tmr_q + 8'd1;
          if (!alarmreset) begin
            state_d = StArmed;
            cnt_d   = 3'd0;
          end else if (snooze_rise && (cnt_q < SnzMax)) begin
            state_d = StSnooze;
            cnt_d   = cnt_q + 3'd1;
            if (snz_sum >= 8'd60) begin
              snz_min_d = snz_sum - 8'd60;
              snz_hrs_d = (hrs == 8'd23) ? 8'd0 : hrs + 8'd1;
            end else begin
              snz_min_d = snz_sum;
              snz_hrs_d = hrs;
            end
          end else if (tmr_q == RingLast) begin
            state_d = StArmed;
            cnt_d   = 3'd0;
          end
        end
        StSnooze: begin
          if (!alarmreset) begin
            state_d = StArmed;
            cnt_d   = 3'd0;
          end else if (snz_rise) begin
            state_d = StRinging;
            tmr_d   = 8'd0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK_2Hz or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      cnt_q         <= 3'd0;
      tmr_q         <= 8'd0;
      snz_min_q     <= 8'd0;
      snz_hrs_q     <= 8'd0;
      alarm_match_q <= 1'b0;
      snz_match_q   <= 1'b0;
      snooze_q      <= 1'b0;
      alrm_q        <= 1'b0;
      snoozing_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmr_q         <= tmr_d;
      snz_min_q     <= snz_min_d;
      snz_hrs_q     <= snz_hrs_d;
      alarm_match_q <= alarm_match;
      snz_match_q   <= snz_match;
      snooze_q      <= snooze;
      // Indicators are registered from the next state so they track state exactly.
      alrm_q        <= (state_d == StRinging);
      snoozing_q    <= (state_d == StSnooze);
    end
  end

  assign alrm       = alrm_q;
  assign snoozing   = snoozing_q;
  assign state      = state_q;
  assign snooze_cnt = cnt_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed bench for alarm_scheduler: a vector table for single-edge behaviour plus
// hand-written sequences for timeout, snooze exhaustion and asynchronous reset.
module tb_alarm_scheduler;

  logic       clk = 1'b0;
  logic       reset, run_clock, activatealarm, alarmreset, snooze;
  logic [7:0] sec, min, hrs, min_alrm, hrs_alrm;
  logic       alrm, snoozing;
  logic [1:0] state;
  logic [2:0] snooze_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       act, arst, snz, run;
    logic [7:0] h, m, s, ah, am;
    logic       e_alrm, e_snz;
    logic [1:0] e_st;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  alarm_scheduler #(.RING_SEC(60), .SNOOZE_MIN(5), .MAX_SNOOZE(3)) dut (
    .CLK_2Hz      (clk),
    .reset        (reset),
    .run_clock    (run_clock),
    .activatealarm(activatealarm),
    .alarmreset   (alarmreset),
    .snooze       (snooze),
    .sec          (sec),
    .min          (min),
    .hrs          (hrs),
    .min_alrm     (min_alrm),
    .hrs_alrm     (hrs_alrm),
    .alrm         (alrm),
    .snoozing     (snoozing),
    .state        (state),
    .snooze_cnt   (snooze_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hrs = h[7:0];
    min = m[7:0];
    sec = s[7:0];
  endtask

  task automatic add(input int act, input int arst, input int snz, input int run,
                     input int h, input int m, input int s, input int ah, input int am,
                     input int ea, input int es, input int est, input int ecnt);
    vec_t v;
    v.act = act[0]; v.arst = arst[0]; v.snz = snz[0]; v.run = run[0];
    v.h = h[7:0]; v.m = m[7:0]; v.s = s[7:0]; v.ah = ah[7:0]; v.am = am[7:0];
    v.e_alrm = ea[0]; v.e_snz = es[0]; v.e_st = est[1:0]; v.e_cnt = ecnt[2:0];
    vq.push_back(v);
  endtask

  task automatic chk_out(input string tag, input int ea, input int es, input int est,
                         input int ecnt);
    chk({tag, "_alrm"}, int'(alrm), ea);
    chk({tag, "_snoozing"}, int'(snoozing), es);
    chk({tag, "_state"}, int'(state), est);
    chk({tag, "_cnt"}, int'(snooze_cnt), ecnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //   act arst snz run  h  m  s   ah am  alrm snz st cnt
    add(1, 1, 0, 1,  5, 29, 59,  5, 30,  0, 0, 1, 0);   // release -> ARMED
    add(1, 1, 0, 1,  5, 29, 59,  5, 30,  0, 0, 1, 0);
    add(1, 1, 0, 1,  5, 30,  0,  5, 30,  1, 0, 2, 0);   // match -> RINGING
    add(1, 1, 0, 1,  5, 30,  0,  5, 30,  1, 0, 2, 0);   // held match
    add(1, 0, 0, 1,  5, 30,  0,  5, 30,  0, 0, 1, 0);   // dismiss
    add(1, 1, 0, 1,  5, 30,  0,  5, 30,  0, 0, 1, 0);   // still held: no retrigger
    add(1, 1, 0, 1,  5, 30,  1,  5, 30,  0, 0, 1, 0);
    add(1, 1, 0, 1, 23, 57, 59, 23, 58,  0, 0, 1, 0);
    add(1, 1, 0, 1, 23, 58,  0, 23, 58,  1, 0, 2, 0);
    add(1, 1, 1, 1, 23, 58,  0, 23, 58,  0, 1, 3, 1);   // snooze -> target 00:03
    add(1, 1, 0, 1, 23, 58,  1, 23, 58,  0, 1, 3, 1);
    add(1, 1, 0, 1,  0,  2, 59, 23, 58,  0, 1, 3, 1);
    add(1, 1, 0, 1,  0,  3,  0, 23, 58,  1, 0, 2, 1);   // wrapped snooze match
    add(1, 0, 1, 1,  0,  3,  1, 23, 58,  0, 0, 1, 0);   // dismiss beats snooze
    add(1, 1, 0, 1,  0,  3,  2, 23, 58,  0, 0, 1, 0);
    add(1, 1, 0, 1, 23, 57, 59, 23, 58,  0, 0, 1, 0);
    add(1, 1, 0, 1, 23, 58,  0, 23, 58,  1, 0, 2, 0);
    add(1, 1, 1, 1, 23, 58,  1, 23, 58,  0, 1, 3, 1);
    add(1, 1, 0, 1, 23, 58,  0, 23, 58,  0, 1, 3, 1);   // alarm match ignored in SNOOZE
    add(0, 1, 0, 1, 23, 58,  1, 23, 58,  0, 0, 0, 0);   // deactivate -> IDLE
    add(1, 1, 0, 1, 23, 58,  1, 23, 58,  0, 0, 1, 0);
    add(1, 1, 0, 0, 23, 58,  0, 23, 58,  0, 0, 1, 0);   // run_clock low gates match
    add(1, 1, 0, 1, 23, 58,  0, 23, 58,  1, 0, 2, 0);
    add(1, 0, 0, 1, 23, 58,  0, 23, 58,  0, 0, 1, 0);
    add(1, 1, 0, 1, 23, 58,  1, 23, 58,  0, 0, 1, 0);

    reset = 1'b0; run_clock = 1'b1; activatealarm = 1'b1; alarmreset = 1'b1; snooze = 1'b0;
    set_time(5, 29, 59);
    hrs_alrm = 8'd5; min_alrm = 8'd30;
    #12;
    chk_out("reset", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vq[i]) begin
      activatealarm = vq[i].act;
      alarmreset    = vq[i].arst;
      snooze        = vq[i].snz;
      run_clock     = vq[i].run;
      hrs = vq[i].h; min = vq[i].m; sec = vq[i].s;
      hrs_alrm = vq[i].ah; min_alrm = vq[i].am;
      tick();
      chk_out($sformatf("v%0d", i), int'(vq[i].e_alrm), int'(vq[i].e_snz), int'(vq[i].e_st),
              int'(vq[i].e_cnt));
    end
    activatealarm = 1'b1; alarmreset = 1'b1; snooze = 1'b0; run_clock = 1'b1;

    // Unattended ring: alrm high for exactly 2*RING_SEC cycles.
    hrs_alrm = 8'd5; min_alrm = 8'd30;
    set_time(5, 29, 59);
    tick();
    set_time(5, 30, 0);
    tick();
    chk("timeout_start", int'(alrm), 1);
    set_time(5, 30, 1);
    n = 1;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (!alrm) break;
      n++;
    end
    chk("timeout_cycles", n, 120);
    chk("timeout_state", int'(state), 1);
    chk("timeout_cnt", int'(snooze_cnt), 0);

    // Three snoozes, then a fourth request is ignored.
    set_time(5, 29, 59);
    tick();
    set_time(5, 30, 0);
    tick();
    chk_out("snzx_ring", 1, 0, 2, 0);
    for (int k = 1; k <= 3; k++) begin
      snooze = 1'b1;
      tick();
      snooze = 1'b0;
      chk_out($sformatf("snzx%0d_snooze", k), 0, 1, 3, k);
      set_time(5, 30 + 5 * k - 1, 59);
      tick();
      set_time(5, 30 + 5 * k, 0);
      tick();
      chk_out($sformatf("snzx%0d_ring", k), 1, 0, 2, k);
    end
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    chk_out("snzx_fourth", 1, 0, 2, 3);
    alarmreset = 1'b0;
    tick();
    alarmreset = 1'b1;
    chk_out("snzx_dismiss", 0, 0, 1, 0);

    // Asynchronous reset between edges while ringing.
    set_time(6, 29, 59);
    hrs_alrm = 8'd6;
    tick();
    set_time(6, 30, 0);
    tick();
    chk("areset_ring", int'(alrm), 1);
    set_time(6, 30, 1);
    #2;
    reset = 1'b0;
    #1;
    chk_out("areset_async", 0, 0, 0, 0);
    tick();
    chk("areset_hold_state", int'(state), 0);
    reset = 1'b1;
    tick();
    chk_out("areset_release", 0, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
